// File: rtl/alu_seq_ctrl_if.sv
// Byte-stream and ALU operand/result bundle for alu_seq_ctrl.
// master = the sequencer, slave = the byte bus plus ALU side.
interface alu_seq_ctrl_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_shamt;
  logic [2:0] alu_ctrl;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       alu_neg;
  logic       alu_carry;
  logic       alu_ovf;
  logic       busy;

  modport master (
    input  in_valid, in_data, out_ready,
           alu_result, alu_zero, alu_neg, alu_carry, alu_ovf,
    output in_ready, out_valid, out_data,
           alu_a, alu_b, alu_shamt, alu_ctrl, busy
  );

  modport slave (
    output in_valid, in_data, out_ready,
           alu_result, alu_zero, alu_neg, alu_carry, alu_ovf,
    input  in_ready, out_valid, out_data,
           alu_a, alu_b, alu_shamt, alu_ctrl, busy
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Byte-serial command front-end for the ALU: collects (cmd, A, B), runs one EXEC cycle, returns result and optional flags.
// Optional feature macro: ALU_SEQ_CHAIN_EN (command bit 4 reuses the last result as operand A).
module alu_seq_ctrl (
  input  logic           clk,
  input  logic           rst,
  alu_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    GET_A,
    GET_B,
    EXEC,
    SEND_R,
    SEND_F
  } state_t;

  state_t     state;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [2:0] ctrl_q;
  logic       flags_req_q;
  logic [7:0] res_q;
  logic [3:0] flags_q;
  logic       out_valid_q;
  logic [7:0] out_data_q;

  logic accepting;
  logic in_fire;
  logic out_fire;
  logic unused_cmd_bits;

  assign accepting = (state == IDLE) || (state == GET_A) || (state == GET_B);
  assign in_fire   = bus.in_valid & bus.in_ready;
  assign out_fire  = out_valid_q & bus.out_ready;

  // Reset gates in_ready combinationally so no byte can be taken on a reset edge.
  assign bus.in_ready  = accepting & ~rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_shamt = a_q[3:0];
  assign bus.alu_ctrl  = ctrl_q;
  assign bus.busy      = (state != IDLE);

  assign unused_cmd_bits = ^bus.in_data[7:4];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      ctrl_q      <= 3'd0;
      flags_req_q <= 1'b0;
      res_q       <= 8'h00;
      flags_q     <= 4'h0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (in_fire) begin
            ctrl_q      <= bus.in_data[2:0];
            flags_req_q <= bus.in_data[3];
`ifdef ALU_SEQ_CHAIN_EN
            if (bus.in_data[4]) begin
              a_q   <= res_q;
              state <= GET_B;
            end else begin
              state <= GET_A;
            end
`else
            state <= GET_A;
`endif
          end
        end
        GET_A: begin
          if (in_fire) begin
            a_q   <= bus.in_data;
            state <= GET_B;
          end
        end
        GET_B: begin
          if (in_fire) begin
            b_q   <= bus.in_data;
            state <= EXEC;
          end
        end
        EXEC: begin
          res_q       <= bus.alu_result;
          flags_q     <= {bus.alu_ovf, bus.alu_carry, bus.alu_neg, bus.alu_zero};
          out_data_q  <= bus.alu_result;
          out_valid_q <= 1'b1;
          state       <= SEND_R;
        end
        SEND_R: begin
          if (out_fire) begin
            if (flags_req_q) begin
              out_data_q <= {4'b0000, flags_q};
              state      <= SEND_F;
            end else begin
              out_valid_q <= 1'b0;
              out_data_q  <= 8'h00;
              state       <= IDLE;
            end
          end
        end
        SEND_F: begin
          if (out_fire) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl with a small behavioural ALU on the slave side.
// Build with or without ALU_SEQ_CHAIN_EN; the chain scenario follows the macro.
module tb_alu_seq_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  alu_seq_ctrl_if bus ();

  alu_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: 0 ADD, 1 SUB (carry = no borrow), 2 AND, 3 OR, 4 XOR.
  always_comb begin
    logic [8:0] wide;
    wide          = 9'd0;
    bus.alu_carry = 1'b0;
    bus.alu_ovf   = 1'b0;
    case (bus.alu_ctrl)
      3'd0: begin
        wide          = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_carry = wide[8];
        bus.alu_ovf   = (bus.alu_a[7] == bus.alu_b[7]) && (wide[7] != bus.alu_a[7]);
      end
      3'd1: begin
        wide          = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
        bus.alu_carry = (bus.alu_a >= bus.alu_b);
        bus.alu_ovf   = (bus.alu_a[7] != bus.alu_b[7]) && (wide[7] != bus.alu_a[7]);
      end
      3'd2: wide = {1'b0, bus.alu_a & bus.alu_b};
      3'd3: wide = {1'b0, bus.alu_a | bus.alu_b};
      3'd4: wide = {1'b0, bus.alu_a ^ bus.alu_b};
      default: wide = 9'd0;
    endcase
    bus.alu_result = wide[7:0];
    bus.alu_zero   = (wide[7:0] == 8'h00);
    bus.alu_neg    = wide[7];
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Presents one byte and holds it until accepted; returns just after the following falling edge.
  task automatic send_byte(input logic [7:0] b);
    int cnt;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    cnt = 0;
    while (!bus.in_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 50) begin
      total++;
      bad++;
      $display("[TB] FAIL send_timeout: in_ready stayed 0, required 1 for byte %h", b);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_out_valid();
    int cnt;
    cnt = 0;
    while (!bus.out_valid && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 50) begin
      total++;
      bad++;
      $display("[TB] FAIL out_timeout: out_valid stayed 0, required 1");
    end
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_in_ready: got %b want 0", bus.in_ready);
    end
    total++;
    if ({bus.out_valid, bus.busy} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL reset_valid_busy: got %b want 00", {bus.out_valid, bus.busy});
    end
    total++;
    if ({bus.out_data, bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.alu_shamt} !== 31'd0) begin
      bad++;
      $display("[TB] FAIL reset_regs: got out=%h a=%h b=%h ctrl=%h sh=%h want all 0",
               bus.out_data, bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.alu_shamt);
    end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_release_ready: got %b want 1", bus.in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_add();
    bus.out_ready = 1'b1;
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h03);
    bus.in_valid = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL add_exec_valid: got %b want 0 one edge after B", bus.out_valid);
    end
    @(negedge clk);
    total++;
    if ({bus.out_valid, bus.out_data} !== {1'b1, 8'h08}) begin
      bad++;
      $display("[TB] FAIL add_beat: got v=%b d=%h want v=1 d=08", bus.out_valid, bus.out_data);
    end
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({bus.out_valid, bus.busy} !== 2'b00) begin
        bad++;
        $display("[TB] FAIL add_no_second: got v=%b busy=%b want 0 0", bus.out_valid, bus.busy);
      end
    end
  endtask

  task automatic test_sub_flags();
    bus.out_ready = 1'b1;
    send_byte(8'h09);
    send_byte(8'h03);
    send_byte(8'h05);
    bus.in_valid = 1'b0;
    wait_out_valid();
    total++;
    if (bus.out_data !== 8'hFE) begin
      bad++;
      $display("[TB] FAIL sub_result: got %h want fe", bus.out_data);
    end
    @(negedge clk);
    total++;
    if ({bus.out_valid, bus.out_data} !== {1'b1, 8'h02}) begin
      bad++;
      $display("[TB] FAIL sub_flags: got v=%b d=%h want v=1 d=02", bus.out_valid, bus.out_data);
    end
    @(negedge clk);
    total++;
    if ({bus.out_valid, bus.busy} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL sub_done: got v=%b busy=%b want 0 0", bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    send_byte(8'h02);
    send_byte(8'hF0);
    send_byte(8'h3C);
    bus.in_valid = 1'b0;
    @(negedge clk);
    repeat (3) begin
      total++;
      if ({bus.out_valid, bus.out_data, bus.in_ready} !== {1'b1, 8'h30, 1'b0}) begin
        bad++;
        $display("[TB] FAIL bp_hold: got v=%b d=%h rdy=%b want v=1 d=30 rdy=0",
                 bus.out_valid, bus.out_data, bus.in_ready);
      end
      @(negedge clk);
    end
    total++;
    if (bus.alu_shamt !== 4'h0) begin
      bad++;
      $display("[TB] FAIL bp_shamt: got %h want 0", bus.alu_shamt);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.out_valid, bus.busy} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL bp_release: got v=%b busy=%b want 0 0", bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    int beats;
    bus.out_ready = 1'b1;
    send_byte(8'h00);
    send_byte(8'h11);
    bus.in_valid = 1'b0;
    do_reset();
    total++;
    if ({bus.busy, bus.in_ready, bus.alu_a} !== {1'b0, 1'b1, 8'h00}) begin
      bad++;
      $display("[TB] FAIL mid_reset_state: got busy=%b rdy=%b a=%h want 0 1 00",
               bus.busy, bus.in_ready, bus.alu_a);
    end
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h02);
    bus.in_valid = 1'b0;
    beats = 0;
    repeat (6) begin
      if (bus.out_valid) begin
        beats++;
        total++;
        if (bus.out_data !== 8'h03) begin
          bad++;
          $display("[TB] FAIL mid_beat: got %h want 03", bus.out_data);
        end
      end
      @(negedge clk);
    end
    total++;
    if (beats != 1) begin
      bad++;
      $display("[TB] FAIL mid_beat_count: got %0d want 1", beats);
    end
  endtask

  task automatic test_reset_pending();
    bus.out_ready = 1'b0;
    send_byte(8'h08);
    send_byte(8'h01);
    send_byte(8'h01);
    bus.in_valid = 1'b0;
    wait_out_valid();
    do_reset();
    total++;
    if ({bus.out_valid, bus.out_data, bus.busy} !== {1'b0, 8'h00, 1'b0}) begin
      bad++;
      $display("[TB] FAIL pend_reset: got v=%b d=%h busy=%b want 0 00 0",
               bus.out_valid, bus.out_data, bus.busy);
    end
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL pend_no_beat: got v=%b want 0", bus.out_valid);
      end
    end
  endtask

  task automatic test_chain();
    bus.out_ready = 1'b1;
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h03);
    bus.in_valid = 1'b0;
    wait_out_valid();
    total++;
    if (bus.out_data !== 8'h08) begin
      bad++;
      $display("[TB] FAIL chain_first: got %h want 08", bus.out_data);
    end
    @(negedge clk);
    send_byte(8'h10);
    send_byte(8'h01);
    bus.in_valid = 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
    wait_out_valid();
    total++;
    if ({bus.out_data, bus.alu_a} !== {8'h09, 8'h08}) begin
      bad++;
      $display("[TB] FAIL chain_result: got d=%h a=%h want d=09 a=08", bus.out_data, bus.alu_a);
    end
    @(negedge clk);
`else
    repeat (4) begin
      total++;
      if ({bus.out_valid, bus.busy, bus.in_ready, bus.alu_a} !== {1'b0, 1'b1, 1'b1, 8'h01}) begin
        bad++;
        $display("[TB] FAIL nochain_wait: got v=%b busy=%b rdy=%b a=%h want 0 1 1 01",
                 bus.out_valid, bus.busy, bus.in_ready, bus.alu_a);
      end
      @(negedge clk);
    end
    send_byte(8'h02);
    bus.in_valid = 1'b0;
    wait_out_valid();
    total++;
    if (bus.out_data !== 8'h03) begin
      bad++;
      $display("[TB] FAIL nochain_result: got %h want 03", bus.out_data);
    end
    @(negedge clk);
`endif
  endtask

  task automatic test_input_gating();
    bus.out_ready = 1'b0;
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h03);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hA1 + 8'(i * 17);
      @(negedge clk);
    end
    total++;
    if ({bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.alu_shamt} !== {8'h05, 8'h03, 3'd0, 4'h5}) begin
      bad++;
      $display("[TB] FAIL gate_operands: got a=%h b=%h ctrl=%h sh=%h want 05 03 0 5",
               bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.alu_shamt);
    end
    total++;
    if ({bus.out_valid, bus.out_data, bus.in_ready} !== {1'b1, 8'h08, 1'b0}) begin
      bad++;
      $display("[TB] FAIL gate_output: got v=%b d=%h rdy=%b want 1 08 0",
               bus.out_valid, bus.out_data, bus.in_ready);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.out_valid, bus.busy} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL gate_done: got v=%b busy=%b want 0 0", bus.out_valid, bus.busy);
    end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_add();
    test_sub_flags();
    test_backpressure();
    test_reset_mid_frame();
    test_reset_pending();
    test_chain();
    test_input_gating();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequential command front-end for the `ALU` datapath. It accepts byte-serial command frames (opcode, operand A, operand B) over a valid/ready input stream and drives the registered operands and opcode into the combinational `ALU`. It captures `RESULT` and the four flags, then returns the result, and optionally a packed flag byte, over a valid/ready output stream. It sits between the pad-level byte bus and the `ALU` instance, and is the issuing/collecting end of the ALU operand/result interface.

## Interface
Parameters: none (all widths fixed by the `ALU`).

Ports (clock and reset first):
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  reset; **synchronous, active-high** (one clock `clk`; synchronous active-high reset `rst`)
- `in_valid`  in  1  input byte valid
- `in_data`  in  8  input byte (command frame stream)
- `in_ready`  out  1  block can accept a byte this cycle
- `out_valid`  out  1  output byte valid
- `out_data`  out  8  output byte (result, then optional flag byte)
- `out_ready`  in  1  downstream accepts the output byte
- `alu_a`  out  8  operand A to `ALU.A`
- `alu_b`  out  8  operand B to `ALU.B`
- `alu_shamt`  out  4  shift amount to `ALU.s_amt`; always equals `alu_a[3:0]`
- `alu_ctrl`  out  3  to `ALU.ALU_control`
- `alu_result`  in  8  from `ALU.RESULT`
- `alu_zero`, `alu_neg`, `alu_carry`, `alu_ovf`  in  1 each  from `ALU` ZERO/NEGATIVE/CARRY/OVERFLOW
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- Frame format: byte0 = command, byte1 = A, byte2 = B.
  - Command bits: `[2:0]` opcode; `[3]` FLAGS_REQ; `[4]` CHAIN (see Configuration); `[7:5]` ignored.
- A byte transfers on any rising edge where `in_valid & in_ready`.
- States and transitions:
  - IDLE → GET_A on command accept. Opcode and FLAGS_REQ are latched.
  - GET_A → GET_B on A accept.
  - GET_B → EXEC on B accept.
  - EXEC → SEND_R unconditionally after one cycle. At this edge `alu_result` and the flags are captured into registers.
  - SEND_R → (FLAGS_REQ ? SEND_F : IDLE) on `out_valid & out_ready`.
  - SEND_F → IDLE on `out_valid & out_ready`.
- `in_ready` = state ∈ {IDLE, GET_A, GET_B} and `rst` low. It is 0 in EXEC, SEND_R and SEND_F, so frames never overlap.
- `alu_a`, `alu_b` and `alu_ctrl` are registers. Each loads on acceptance of its own byte and holds until overwritten by the next frame. The `ALU` therefore sees stable inputs throughout EXEC.
- SEND_R: `out_data` = captured result.
- SEND_F: `out_data` = {4'b0, ovf, carry, neg, zero}.
- `out_valid` is high only in SEND_R and SEND_F. `out_data` holds stable while `out_valid & ~out_ready`.
- The block performs no arithmetic itself; results and flags are exactly what the `ALU` presents during EXEC.

## Timing
- Reset values: state IDLE; `alu_a`, `alu_b`, `alu_ctrl` = 0; captured result and flags = 0; `out_valid` = 0; `out_data` = 0x00; `busy` = 0.
  - `in_ready` = 0 while `rst` is high, and 1 on the first cycle after `rst` falls.
- Minimum frame: 3 accept cycles, then 1 EXEC cycle. `out_valid` rises on the 2nd edge after B is accepted.
- The earliest next command accept is the cycle after the last output handshake.
- `rst` asserted in any state, including mid-frame or with `out_valid` high: on that edge return to IDLE, discard partial or pending data, and drop `out_valid`. The next accepted byte is a command.
- `in_valid` is ignored while `in_ready` = 0; no byte is latched.
- `out_ready` may be held high continuously. SEND_R → SEND_F then takes exactly one cycle per beat.

## Configuration
- `ALU_SEQ_CHAIN_EN` defined: command bit 4 (CHAIN) set means the frame is 2 bytes (command, B). A is taken from the last captured result (0x00 after reset), and IDLE goes directly to GET_B with `alu_a` loaded from the captured result.
- Not defined: bit 4 is ignored, every frame is 3 bytes, and no result-feedback path exists.

## Test plan
- ADD: bytes 0x00, 0x05, 0x03 back-to-back with `out_ready`=1 → one out beat 0x08; `out_valid` 2 edges after B accept; no second beat.
- SUB with flags: 0x09, 0x03, 0x05 → beats 0xFE then 0x02 (neg=1, others 0). `busy` low after the 2nd handshake.
- Backpressure: AND frame 0x02, 0xF0, 0x3C with `out_ready`=0 for 3 cycles → `out_valid`=1 and `out_data`=0x30 held stable; `in_ready`=0 throughout; beat completes when `out_ready` rises.
- Reset mid-frame: accept 0x00, 0x11, assert `rst` one cycle, then send 0x00, 0x01, 0x02 → single beat 0x03; nothing emitted for the aborted frame.
- Chain (macro defined): ADD 5+3 → 0x08, then 0x10, 0x01 → 0x09. Macro undefined: same 0x10 byte is treated as ADD and waits for the A byte.
- Input gating: hold `in_valid`=1 with changing `in_data` during EXEC/SEND_R → `alu_a`/`alu_b`/`alu_ctrl` unchanged; output values unaffected.
